imem_loader: RTL

//  Write-side counterpart of the byte-addressed instruction memory: receives a program image as a

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_timeout.sv | 35 +++
 rtl/imem_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, default sizes
// and the running checksum helper.
package imem_loader_pkg;

  localparam int unsigned MEM_BYTES_DEF = 1024;
  localparam int unsigned TIMEOUT_DEF   = 100000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle counter: counts cycles while enabled and not cleared, and flags the
// cycle whose idle tick would reach TIMEOUT.
module loader_timeout
  import imem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // idle cycle counter, saturating at the expiry point
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear || !enable) begin
      count_r <= '0;
    end else if (count_r != LAST) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && !clear && (count_r == LAST);

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed program image byte by byte, writes it into
// instruction memory and releases the core only once the whole image checks out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
  parameter int unsigned ADDR_W     = $clog2(MEM_BYTES),
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

  state_t      state_r;
  logic [7:0]  len_lo_r;
  logic [7:0]  chk_r;
  logic [17:0] byte_cnt_r;
  logic [17:0] hdr_bytes_s;
  logic [17:0] frame_bytes_s;
  logic        xfer_s;
  logic        tmo_en_s;
  logic        tmo_expired_s;

  assign xfer_s        = rx_valid && rx_ready;
  assign hdr_bytes_s   = {rx_data, len_lo_r, 2'b00};
  assign frame_bytes_s = {word_count, 2'b00};
  assign tmo_en_s      = (state_r == ST_LEN_HI) || (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (xfer_s),
    .enable (tmo_en_s),
    .expired(tmo_expired_s)
  );

  // frame FSM with byte counter, checksum and registered write port / status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (AUTO_START) state_r <= ST_LEN_LO;
      else            state_r <= ST_IDLE;
      rx_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 16'h0000;
      len_lo_r   <= 8'h00;
      chk_r      <= 8'h00;
      byte_cnt_r <= 18'd0;
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r  <= ST_LEN_LO;
            rx_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          // also covers the first cycle after reset, where rx_ready still reads 0
          rx_ready <= 1'b1;
          if (xfer_s) begin
            len_lo_r   <= rx_data;
            chk_r      <= 8'h00;
            byte_cnt_r <= 18'd0;
            state_r    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer_s) begin
            word_count <= {rx_data, len_lo_r};
            if (hdr_bytes_s == 18'd0) begin
              state_r <= ST_CHECK;
            end else if (hdr_bytes_s > MEM_LIMIT) begin
              state_r  <= ST_ERROR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state_r <= ST_PAYLOAD;
            end
          end else if (tmo_expired_s) begin
            state_r  <= ST_ERROR;
            rx_ready <= 1'b0;
            error    <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (xfer_s) begin
            wr_en      <= 1'b1;
            wr_addr    <= byte_cnt_r[ADDR_W-1:0];
            wr_data    <= rx_data;
            chk_r      <= chk_update(chk_r, rx_data);
            byte_cnt_r <= byte_cnt_r + 18'd1;
            if (byte_cnt_r == frame_bytes_s - 18'd1) state_r <= ST_CHECK;
          end else if (tmo_expired_s) begin
            state_r  <= ST_ERROR;
            rx_ready <= 1'b0;
            error    <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (xfer_s) begin
            rx_ready <= 1'b0;
            if (rx_data == chk_r) begin
              state_r  <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r <= ST_ERROR;
              error   <= 1'b1;
            end
          end else if (tmo_expired_s) begin
            state_r  <= ST_ERROR;
            rx_ready <= 1'b0;
            error    <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_ERROR;
          rx_ready <= 1'b0;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule
